// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar slave-port stage: FSM encoding,
// default widths, timeout read data and master-id encoding.
package xbar_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StRdata = 2'd2
    } state_e;

    // Returned to a reading master whose transaction was abandoned by timeout
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Master ids; MST_NONE means no grant this cycle
    localparam logic [1:0] MST_NONE = 2'd0;
    localparam logic [1:0] MST_1    = 2'd1;
    localparam logic [1:0] MST_2    = 2'd2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter: combinational grant, registered last_grant.
module rr_arbiter_2
    import xbar_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_elig_1,
    input  logic       i_elig_2,
    input  logic       i_strobe,
    output logic [1:0] o_grant
);

    logic [1:0] r_last_grant;

    // Pick the lone eligible master, or the one not granted last time on contention
    always_comb begin
        o_grant = MST_NONE;
        if (i_elig_1 && i_elig_2) begin
            o_grant = (r_last_grant == MST_1) ? MST_2 : MST_1;
        end else if (i_elig_1) begin
            o_grant = MST_1;
        end else if (i_elig_2) begin
            o_grant = MST_2;
        end
    end

    // Remember the winner; reset value makes master 1 win the first contention
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_last_grant <= MST_2;
        end else if (i_strobe && (o_grant != MST_NONE)) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Crossbar slave-port stage: round-robin arbitration of two masters onto one
// slave port, request latching and ack/rdata return to the granted master.
// Optional BUSY timeout enabled by defining ARB_TIMEOUT_EN.
module slave_port_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              master_1_req,
    input  logic [ADDR_W-1:0] master_1_addr,
    input  logic              master_1_cmd,
    input  logic [DATA_W-1:0] master_1_wdata,
    output logic              master_1_ack,
    output logic [DATA_W-1:0] master_1_rdata,
    input  logic              master_2_req,
    input  logic [ADDR_W-1:0] master_2_addr,
    input  logic              master_2_cmd,
    input  logic [DATA_W-1:0] master_2_wdata,
    output logic              master_2_ack,
    output logic [DATA_W-1:0] master_2_rdata,
    output logic              slave_req,
    output logic [ADDR_W-1:0] slave_addr,
    output logic              slave_cmd,
    output logic [DATA_W-1:0] slave_wdata,
    input  logic              slave_ack,
    input  logic [DATA_W-1:0] slave_rdata,
    output logic              arb_timeout
);

    state_e            r_state;
    logic [1:0]        r_grant;
    logic              r_slave_req;
    logic [ADDR_W-1:0] r_slave_addr;
    logic              r_slave_cmd;
    logic [DATA_W-1:0] r_slave_wdata;
    logic              r_m1_ack;
    logic              r_m2_ack;
    logic [DATA_W-1:0] r_m1_rdata;
    logic [DATA_W-1:0] r_m2_rdata;

    logic [1:0]        w_grant;
    logic              w_done;
    logic [DATA_W-1:0] w_done_data;
    logic              w_timeout;

    // A master whose ack is currently high is masked for that cycle
    rr_arbiter_2 u_rr_arbiter_2 (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_elig_1 (master_1_req & ~r_m1_ack),
        .i_elig_2 (master_2_req & ~r_m2_ack),
        .i_strobe (r_state == StIdle),
        .o_grant  (w_grant)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_arb_timeout;

    // BUSY cycle counter, cleared on every grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt     <= '0;
            r_arb_timeout <= 1'b0;
        end else begin
            r_arb_timeout <= w_timeout;
            if (r_state == StIdle) begin
                r_tmo_cnt <= '0;
            end else if (r_state == StBusy) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    assign arb_timeout = r_arb_timeout;
`else
    assign arb_timeout = 1'b0;
`endif

    // Decide whether the granted master completes at the coming edge, and with what data
    always_comb begin
        w_done      = 1'b0;
        w_done_data = '0;
        w_timeout   = 1'b0;
        case (r_state)
            StBusy: begin
                if (slave_ack) begin
                    w_done = r_slave_cmd;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_done      = 1'b1;
                    w_timeout   = 1'b1;
                    w_done_data = r_slave_cmd ? '0 : DATA_W'(TIMEOUT_RDATA);
                end
`endif
            end
            StRdata: begin
                w_done      = 1'b1;
                w_done_data = slave_rdata;
            end
            default: ;
        endcase
    end

    // Main FSM with registered slave-side latches and master-side ack/rdata
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_grant       <= MST_NONE;
            r_slave_req   <= 1'b0;
            r_slave_addr  <= '0;
            r_slave_cmd   <= 1'b0;
            r_slave_wdata <= '0;
            r_m1_ack      <= 1'b0;
            r_m2_ack      <= 1'b0;
            r_m1_rdata    <= '0;
            r_m2_rdata    <= '0;
        end else begin
            r_m1_ack   <= w_done && (r_grant == MST_1);
            r_m2_ack   <= w_done && (r_grant == MST_2);
            r_m1_rdata <= (w_done && (r_grant == MST_1)) ? w_done_data : '0;
            r_m2_rdata <= (w_done && (r_grant == MST_2)) ? w_done_data : '0;
            case (r_state)
                StIdle: begin
                    if (w_grant != MST_NONE) begin
                        r_state     <= StBusy;
                        r_grant     <= w_grant;
                        r_slave_req <= 1'b1;
                        if (w_grant == MST_1) begin
                            r_slave_addr  <= master_1_addr;
                            r_slave_cmd   <= master_1_cmd;
                            r_slave_wdata <= master_1_wdata;
                        end else begin
                            r_slave_addr  <= master_2_addr;
                            r_slave_cmd   <= master_2_cmd;
                            r_slave_wdata <= master_2_wdata;
                        end
                    end
                end
                StBusy: begin
                    // slave_req is high through the ack edge so the slave can load rdata
                    if (slave_ack) begin
                        r_slave_req <= 1'b0;
                        r_state     <= r_slave_cmd ? StIdle : StRdata;
                    end else if (w_timeout) begin
                        r_slave_req <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StRdata: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state     <= StIdle;
                    r_slave_req <= 1'b0;
                end
            endcase
        end
    end

    assign slave_req      = r_slave_req;
    assign slave_addr     = r_slave_addr;
    assign slave_cmd      = r_slave_cmd;
    assign slave_wdata    = r_slave_wdata;
    assign master_1_ack   = r_m1_ack;
    assign master_2_ack   = r_m2_ack;
    assign master_1_rdata = r_m1_rdata;
    assign master_2_rdata = r_m2_rdata;

endmodule
